router_dest_rx: RTL and testbench
=================================

Name: router_dest_rx

Overview:
- Destination-side reader for one router output FIFO; one instance per output port.
- Drains packets from the FIFO through its read_enb/empty/data_out interface.
- Reassembles each packet (header, payload, parity), checks parity and address, and presents bytes to the client with packet framing.
- Must keep reads flowing so the router's 30-cycle soft-reset timeout does not fire while the client is ready.

Parameters:
- PORT_ID, 2'd0, destination address this port serves; header addr[1:0] compared against it.
- CNT_W, 16, width of statistics counters (used only with STATS_EN).

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  reset, synchronous, active-low
- soft_reset  in  1  router soft reset for this port; FIFO contents discarded
- fifo_empty  in  1  FIFO empty flag; valid data available when low
- fifo_data  in  8  FIFO registered data_out; valid one cycle after an accepted read
- client_ready  in  1  client can take a byte two cycles from now; gates read issue
- read_enb  out  1  FIFO read strobe (combinational from state, fifo_empty, client_ready)
- byte_out  out  8  delivered byte
- byte_valid  out  1  byte_out valid; presented unconditionally one cycle after read_enb
- sop  out  1  with byte_valid, marks the header byte
- eop  out  1  with byte_valid, marks the parity byte
- pkt_len  out  6  payload length of the current packet, from header[7:2]
- pkt_addr  out  2  header[1:0] of the current packet
- pkt_done  out  1  one-cycle pulse after the parity byte is checked
- parity_err  out  1  valid with pkt_done; computed parity != received parity
- addr_err  out  1  valid with pkt_done; pkt_addr != PORT_ID
- pkt_abort  out  1  one-cycle pulse when soft_reset kills an in-flight packet
- busy  out  1  high from header read issue until pkt_done or abort

Behaviour:
- Reset (resetn low at clock edge): state IDLE; all outputs 0; counters, length and parity registers cleared. Reset has priority over soft_reset.
- Read acceptance: a read is accepted when read_enb is high and fifo_empty is low. read_enb is never driven while fifo_empty is high.
- Pipeline flag: rd_d = previous-cycle accepted read. byte_valid = rd_d; byte_out = fifo_data.
- IDLE:
  - read_enb = ~fifo_empty & client_ready.
  - On an accepted read: go to HDR; busy=1.
- HDR (waiting for header data):
  - read_enb = 0.
  - When rd_d: latch len = fifo_data[7:2] and addr = fifo_data[1:0]; parity_acc = fifo_data; sop=1; issued = 0; go to BODY.
- BODY:
  - read_enb = ~fifo_empty & client_ready & (issued < len+1); issued counts payload and parity reads.
  - Each returned byte (rd_d): increment rcvd.
    - If rcvd < len: parity_acc ^= byte.
    - If rcvd == len: byte is parity; eop=1; store cmp = (parity_acc != byte); go to DONE.
  - Counters issued and rcvd are 7 bits so len=63 (64 reads) does not wrap.
  - len==0: exactly one read follows the header, and it is the parity byte.
- DONE:
  - read_enb = 0; pkt_done=1 for one cycle; parity_err = cmp; addr_err = (addr != PORT_ID); busy=0.
  - Go to IDLE. The next header read may issue the following cycle, giving a minimum 1-cycle gap between packets.
- Stalls: fifo_empty high or client_ready low mid-BODY holds issue. State, counters and parity_acc are held. A byte already in flight is still delivered.
- soft_reset (resetn high):
  - From any state other than IDLE/DONE: pulse pkt_abort, go to IDLE, clear counters; byte_valid forced 0 that cycle and the next; no pkt_done.
  - In IDLE: no effect beyond suppressing read_enb that cycle.
- Simultaneous soft_reset and a DONE cycle: pkt_done wins; no abort.
- pkt_len and pkt_addr hold their last values until the next header.

Optional Feature:
STATS_EN
- Defined: adds outputs pkt_count[CNT_W-1:0], err_count[CNT_W-1:0], abort_count[CNT_W-1:0].
  - pkt_count increments on pkt_done.
  - err_count increments on pkt_done & (parity_err | addr_err).
  - abort_count increments on pkt_abort.
  - All counters saturate at all-ones and clear on resetn only.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Good packet, PORT_ID=1: header 8'h0D, payload 11,22,33, parity 0D, client_ready=1 -> 5 read_enb pulses; byte_valid bytes 0D(sop),11,22,33,0D(eop); pkt_len=3, pkt_addr=1; pkt_done with parity_err=0, addr_err=0.
- Same packet with parity byte 0E -> pkt_done with parity_err=1; addr_err=0.
- Zero length: header 8'h00, parity 8'h00, PORT_ID=0 -> exactly 2 reads; sop and eop on consecutive byte_valid; parity_err=0.
- Stalls: fifo_empty high 4 cycles after the 2nd payload byte, then client_ready low 3 cycles -> read_enb never high while either stall condition holds; byte order unchanged; pkt_done with parity_err=0.
- Abort: soft_reset after the 2nd payload byte of a len-5 packet -> pkt_abort pulse, no pkt_done, busy=0; the next packet (header 8'h05, parity 8'h05) completes cleanly.
- Max length: len=63 (header 8'hFC) -> 65 reads total; eop on the 65th byte; no counter wrap. With STATS_EN: pkt_count=1, err_count matches the injected errors.

Source files
------------

// File: rtl/router_dest_rx.sv
// router_dest_rx: destination-side reader for one router output FIFO.
// Drains packets (header, payload, parity), checks parity and address,
// and delivers bytes to the client with sop/eop framing.
// Optional macro STATS_EN adds saturating packet/error/abort counters.
module router_dest_rx #(
  parameter logic [1:0]  PORT_ID = 2'd0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data,
  input  logic             client_ready,
  output logic             read_enb,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic             sop,
  output logic             eop,
  output logic [5:0]       pkt_len,
  output logic [1:0]       pkt_addr,
  output logic             pkt_done,
  output logic             parity_err,
  output logic             addr_err,
  output logic             pkt_abort,
`ifdef STATS_EN
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] abort_count,
`endif
  output logic             busy
);

  // 7-bit read/return counters so a 63-byte payload plus parity never wraps
  localparam int unsigned CW = 7;

  typedef enum logic [1:0] {IDLE, HDR, BODY, DONE} state_t;

  state_t          state;
  logic            rd_d;
  logic [5:0]      len;
  logic [1:0]      addr;
  logic [7:0]      parity_acc;
  logic [CW-1:0]   issued;
  logic [CW-1:0]   rcvd;

  logic            rd_acc;
  logic            kill;
  logic            last_byte;
  logic [CW-1:0]   len_ext;

  assign len_ext   = CW'(len);
  assign rd_acc    = read_enb & ~fifo_empty;
  // soft reset only aborts while a packet is actually in flight
  assign kill      = soft_reset & ((state == HDR) | (state == BODY));
  assign last_byte = rd_d & (state == BODY) & (rcvd == len_ext);

  assign byte_out   = fifo_data;
  assign byte_valid = rd_d & ~kill;
  assign sop        = rd_d & ~kill & (state == HDR);
  assign eop        = last_byte & ~kill;
  assign pkt_len    = len;
  assign pkt_addr   = addr;

  // Read issue: header from IDLE, payload+parity from BODY, never when empty
  always_comb begin
    read_enb = 1'b0;
    case (state)
      IDLE:    read_enb = ~fifo_empty & client_ready & ~soft_reset;
      BODY:    read_enb = ~fifo_empty & client_ready & ~soft_reset &
                          (issued < (len_ext + CW'(1)));
      default: read_enb = 1'b0;
    endcase
  end

  // Packet FSM with registered status pulses
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      rd_d       <= 1'b0;
      len        <= '0;
      addr       <= '0;
      parity_acc <= '0;
      issued     <= '0;
      rcvd       <= '0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      pkt_abort  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rd_d       <= rd_acc;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      pkt_abort  <= 1'b0;
      if (kill) begin
        state      <= IDLE;
        issued     <= '0;
        rcvd       <= '0;
        parity_acc <= '0;
        busy       <= 1'b0;
        pkt_abort  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (rd_acc) begin
              state <= HDR;
              busy  <= 1'b1;
            end
          end
          HDR: begin
            if (rd_d) begin
              len        <= fifo_data[7:2];
              addr       <= fifo_data[1:0];
              parity_acc <= fifo_data;
              issued     <= '0;
              rcvd       <= '0;
              state      <= BODY;
            end
          end
          BODY: begin
            if (rd_acc) issued <= issued + CW'(1);
            if (rd_d) begin
              rcvd <= rcvd + CW'(1);
              if (rcvd < len_ext) begin
                parity_acc <= parity_acc ^ fifo_data;
              end else begin
                state      <= DONE;
                pkt_done   <= 1'b1;
                parity_err <= (parity_acc != fifo_data);
                addr_err   <= (addr != PORT_ID);
                busy       <= 1'b0;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef STATS_EN
  // Saturating statistics; cleared only by resetn
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pkt_count   <= '0;
      err_count   <= '0;
      abort_count <= '0;
    end else begin
      if (pkt_done && (pkt_count != '1))
        pkt_count <= pkt_count + CNT_W'(1);
      if (pkt_done && (parity_err || addr_err) && (err_count != '1))
        err_count <= err_count + CNT_W'(1);
      if (pkt_abort && (abort_count != '1))
        abort_count <= abort_count + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_router_dest_rx.sv
// Bench for router_dest_rx: FIFO model feeding table-driven packets plus
// hand-written stall, abort and soft-reset-in-idle sequences.
module tb_router_dest_rx;

  logic       clock;
  logic       resetn;
  logic       soft_reset;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       client_ready;
  logic       read_enb;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       sop;
  logic       eop;
  logic [5:0] pkt_len;
  logic [1:0] pkt_addr;
  logic       pkt_done;
  logic       parity_err;
  logic       addr_err;
  logic       pkt_abort;
  logic       busy;
`ifdef STATS_EN
  logic [15:0] pkt_count;
  logic [15:0] err_count;
  logic [15:0] abort_count;
`endif

  router_dest_rx #(.PORT_ID(2'd1), .CNT_W(16)) dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .client_ready(client_ready),
    .read_enb(read_enb), .byte_out(byte_out), .byte_valid(byte_valid),
    .sop(sop), .eop(eop), .pkt_len(pkt_len), .pkt_addr(pkt_addr),
    .pkt_done(pkt_done), .parity_err(parity_err), .addr_err(addr_err),
    .pkt_abort(pkt_abort),
`ifdef STATS_EN
    .pkt_count(pkt_count), .err_count(err_count), .abort_count(abort_count),
`endif
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // FIFO model: registered data_out, contents discarded on soft reset
  logic [7:0] mem [0:511];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic hold_empty = 1'b0;
  assign fifo_empty = (rd_ptr == wr_ptr) || hold_empty;

  always @(posedge clock) begin
    if (soft_reset) rd_ptr <= wr_ptr;
    else if (read_enb && !fifo_empty) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Output monitor
  logic [7:0] log_b [0:1023];
  logic       log_s [0:1023];
  logic       log_e [0:1023];
  int log_n = 0, rd_cnt = 0, viol = 0, stray = 0, done_cnt = 0, abort_cnt = 0;

  always @(negedge clock) begin
    if (byte_valid && log_n < 1024) begin
      log_b[log_n] = byte_out;
      log_s[log_n] = sop;
      log_e[log_n] = eop;
      log_n++;
    end
    if ((sop || eop) && !byte_valid) stray++;
    if (read_enb) rd_cnt++;
    if (read_enb && (fifo_empty || !client_ready)) viol++;
    if (pkt_done) done_cnt++;
    if (pkt_abort) abort_cnt++;
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] base;
    logic [7:0] par;
    logic       perr;
    logic       aerr;
    int         reads;
  } vec_t;

  vec_t vecs [7];

  logic [7:0] exp_b [0:127];
  int exp_n;

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  // payload byte i is (i+1)*base, truncated to 8 bits
  task automatic build(input logic [7:0] hdr, input logic [7:0] base, input logic [7:0] par);
    exp_n = 0;
    exp_b[exp_n++] = hdr;
    for (int i = 0; i < int'(hdr[7:2]); i++) exp_b[exp_n++] = 8'((i + 1) * int'(base));
    exp_b[exp_n++] = par;
  endtask

  task automatic expect_pkt(input string name, input vec_t v, input int log0, input int rd0);
    logic got;
    int   bad, frm;
    got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (pkt_done) begin got = 1'b1; break; end
    end
    chk({name, "_done"}, 32'(got), 32'd1);
    if (got) begin
      chk({name, "_perr"}, 32'(parity_err), 32'(v.perr));
      chk({name, "_aerr"}, 32'(addr_err), 32'(v.aerr));
      chk({name, "_len"}, 32'(pkt_len), 32'(v.hdr[7:2]));
      chk({name, "_addr"}, 32'(pkt_addr), 32'(v.hdr[1:0]));
      chk({name, "_busy"}, 32'(busy), 32'd0);
    end
    @(negedge clock);
    chk({name, "_done_pulse"}, 32'(pkt_done), 32'd0);
    chk({name, "_reads"}, 32'(rd_cnt - rd0), 32'(v.reads));
    chk({name, "_nbytes"}, 32'(log_n - log0), 32'(exp_n));
    bad = 0;
    frm = 0;
    for (int i = 0; i < exp_n && (log0 + i) < log_n; i++) begin
      if (log_b[log0 + i] !== exp_b[i]) bad++;
      if (log_s[log0 + i] !== (i == 0)) frm++;
      if (log_e[log0 + i] !== (i == exp_n - 1)) frm++;
    end
    chk({name, "_bytes"}, 32'(bad), 32'd0);
    chk({name, "_framing"}, 32'(frm), 32'd0);
  endtask

  task automatic run_pkt(input string name, input vec_t v);
    int log0, rd0;
    build(v.hdr, v.base, v.par);
    log0 = log_n;
    rd0  = rd_cnt;
    for (int i = 0; i < exp_n; i++) push(exp_b[i]);
    expect_pkt(name, v, log0, rd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t sv;
    int   log0, rd0, rd_s, done0;
    logic ok;

    // {hdr, payload base, parity byte sent, parity_err, addr_err, reads}; PORT_ID=1
    vecs[0] = '{8'h0D, 8'h11, 8'h0D, 1'b0, 1'b0, 5};   // 11,22,33 good
    vecs[1] = '{8'h0D, 8'h11, 8'h0E, 1'b1, 1'b0, 5};   // bad parity
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 2};   // zero length, addr 0
    vecs[3] = '{8'h09, 8'h40, 8'hC9, 1'b0, 1'b0, 4};   // 40,80
    vecs[4] = '{8'h0A, 8'h01, 8'h09, 1'b0, 1'b1, 4};   // 01,02, addr 2
    vecs[5] = '{8'h04, 8'hFF, 8'h00, 1'b1, 1'b1, 3};   // FF, parity FB expected
    vecs[6] = '{8'hFC, 8'h01, 8'hFC, 1'b0, 1'b1, 65};  // 1..63 xor to 0

    resetn = 1'b0;
    soft_reset = 1'b0;
    client_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_flags", 32'({busy, pkt_done, pkt_abort, byte_valid, sop, eop,
                            parity_err, addr_err, read_enb}), 32'd0);
    chk("reset_len", 32'(pkt_len), 32'd0);
    chk("reset_addr", 32'(pkt_addr), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;

    for (int k = 0; k < 7; k++) begin
      run_pkt($sformatf("vec%0d", k), vecs[k]);
      @(posedge clock); #1;
    end

    // Stall: empty for 4 cycles after 2nd payload read, then client_ready low 3
    sv = vecs[0];
    build(sv.hdr, sv.base, sv.par);
    log0 = log_n;
    rd0  = rd_cnt;
    push(exp_b[0]); push(exp_b[1]); push(exp_b[2]);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clock); #1;
      if (rd_ptr == wr_ptr) begin ok = 1'b1; break; end
    end
    chk("stall_prefix_read", 32'(ok), 32'd1);
    hold_empty = 1'b1;
    rd_s = rd_cnt;
    push(exp_b[3]); push(exp_b[4]);
    repeat (4) @(posedge clock);
    #1;
    hold_empty = 1'b0;
    client_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("stall_no_reads", 32'(rd_cnt - rd_s), 32'd0);
    client_ready = 1'b1;
    expect_pkt("stall", sv, log0, rd0);
    chk("stall_viol", 32'(viol), 32'd0);
    @(posedge clock); #1;

    // Abort a len-5 packet after its 2nd payload byte is delivered
    build(8'h15, 8'h10, 8'h05);
    log0  = log_n;
    done0 = done_cnt;
    for (int i = 0; i < exp_n; i++) push(exp_b[i]);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clock); #1;
      if (log_n >= log0 + 3) begin ok = 1'b1; break; end
    end
    chk("abort_prefix", 32'(ok), 32'd1);
    soft_reset = 1'b1;
    @(negedge clock);
    chk("abort_bv_kill", 32'({byte_valid, sop, eop, read_enb}), 32'd0);
    @(posedge clock); #1;
    soft_reset = 1'b0;
    @(negedge clock);
    chk("abort_pulse", 32'(pkt_abort), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bv_next", 32'(byte_valid), 32'd0);
    @(negedge clock);
    chk("abort_pulse_end", 32'(pkt_abort), 32'd0);
    repeat (5) @(negedge clock);
    chk("abort_no_done", 32'(done_cnt - done0), 32'd0);
    chk("abort_count", 32'(abort_cnt), 32'd1);
    @(posedge clock); #1;
    sv = '{8'h05, 8'h00, 8'h05, 1'b0, 1'b0, 3};
    run_pkt("after_abort", sv);
    @(posedge clock); #1;

    // Soft reset in IDLE only suppresses the read
    push(8'hAA);
    soft_reset = 1'b1;
    @(negedge clock);
    chk("idle_sr_no_read", 32'(read_enb), 32'd0);
    @(posedge clock); #1;
    soft_reset = 1'b0;
    @(negedge clock);
    chk("idle_sr_no_abort", 32'({pkt_abort, busy, byte_valid}), 32'd0);
    chk("hold_len", 32'({pkt_len, pkt_addr}), 32'({6'd1, 2'd1}));
    chk("stray_framing", 32'(stray), 32'd0);
    chk("total_done", 32'(done_cnt), 32'd9);
`ifdef STATS_EN
    chk("stats_pkt", 32'(pkt_count), 32'd9);
    chk("stats_err", 32'(err_count), 32'd5);
    chk("stats_abort", 32'(abort_count), 32'd1);
`endif

    // Reset clears held header fields
    @(posedge clock); #1;
    resetn = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("reset2_len_addr", 32'({pkt_len, pkt_addr}), 32'd0);
    resetn = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
